// File: rtl/reg_file.sv
// Architectural register file with rename tags: tracks the ROB entry that will produce each register
// and resolves decoder operands to a value or a pending ROB id.
module reg_file #(
   parameter int unsigned ROB_WIDTH = 4,
   parameter int unsigned REG_NUM   = 32
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,

   input  logic                 dec_ready,
   input  logic [4:0]           dec_rd,
   input  logic [ROB_WIDTH-1:0] dec_rob_id,
   input  logic [4:0]           dec_rs1,
   input  logic [4:0]           dec_rs2,
   output logic [31:0]          rs1_val,
   output logic [31:0]          rs2_val,
   output logic                 rs1_dep_valid,
   output logic                 rs2_dep_valid,
   output logic [ROB_WIDTH-1:0] rs1_dep,
   output logic [ROB_WIDTH-1:0] rs2_dep,

   input  logic                 commit_ready,
   input  logic [ROB_WIDTH-1:0] commit_rob_id,
   input  logic [4:0]           commit_reg_id,
   input  logic [31:0]          commit_val,

   output logic [ROB_WIDTH-1:0] search_rob_id_1,
   output logic [ROB_WIDTH-1:0] search_rob_id_2,
   input  logic                 search_ready_1,
   input  logic                 search_ready_2,
   input  logic [31:0]          search_val_1,
   input  logic [31:0]          search_val_2
);

   localparam int unsigned XLEN = 32;

   logic [XLEN-1:0]      regs      [REG_NUM];
   logic [ROB_WIDTH-1:0] tag       [REG_NUM];
   logic [REG_NUM-1:0]   tag_valid;

   logic commit_wr;
   logic issue_wr;

   assign commit_wr = commit_ready && (commit_reg_id != 5'd0);
   assign issue_wr  = dec_ready && (dec_rd != 5'd0) && !clear;

   // Commit writes first, then clear or issue override the tag state of the same register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         tag_valid <= '0;
         for (int i = 0; i < REG_NUM; i++) begin
            regs[i] <= '0;
            tag[i]  <= '0;
         end
      end else if (rdy_in) begin
         if (commit_wr) begin
            regs[commit_reg_id] <= commit_val;
            if (tag_valid[commit_reg_id] && (tag[commit_reg_id] == commit_rob_id))
               tag_valid[commit_reg_id] <= 1'b0;
         end
         if (clear) begin
            tag_valid <= '0;
         end else if (issue_wr) begin
            tag_valid[dec_rd] <= 1'b1;
            tag[dec_rd]       <= dec_rob_id;
         end
      end
   end

   // Operand resolve from pre-update state, forwarding same-cycle commit or ROB write-back.
   always_comb begin
      rs1_val         = '0;
      rs1_dep_valid   = 1'b0;
      rs1_dep         = '0;
      search_rob_id_1 = '0;
      if (dec_rs1 != 5'd0) begin
         search_rob_id_1 = tag[dec_rs1];
         if (!tag_valid[dec_rs1]) begin
            rs1_val = regs[dec_rs1];
         end else if (commit_ready && (commit_reg_id == dec_rs1) && (commit_rob_id == tag[dec_rs1])) begin
            rs1_val = commit_val;
         end else if (search_ready_1) begin
            rs1_val = search_val_1;
         end else begin
            rs1_dep_valid = 1'b1;
            rs1_dep       = tag[dec_rs1];
         end
      end
   end

   always_comb begin
      rs2_val         = '0;
      rs2_dep_valid   = 1'b0;
      rs2_dep         = '0;
      search_rob_id_2 = '0;
      if (dec_rs2 != 5'd0) begin
         search_rob_id_2 = tag[dec_rs2];
         if (!tag_valid[dec_rs2]) begin
            rs2_val = regs[dec_rs2];
         end else if (commit_ready && (commit_reg_id == dec_rs2) && (commit_rob_id == tag[dec_rs2])) begin
            rs2_val = commit_val;
         end else if (search_ready_2) begin
            rs2_val = search_val_2;
         end else begin
            rs2_dep_valid = 1'b1;
            rs2_dep       = tag[dec_rs2];
         end
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed rename/commit/clear scenarios, then random traffic against a reference model.
module tb_reg_file;

   localparam int unsigned RW = 4;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          rdy_in;
   logic          clear;
   logic          dec_ready;
   logic [4:0]    dec_rd;
   logic [RW-1:0] dec_rob_id;
   logic [4:0]    dec_rs1;
   logic [4:0]    dec_rs2;
   logic [31:0]   rs1_val, rs2_val;
   logic          rs1_dep_valid, rs2_dep_valid;
   logic [RW-1:0] rs1_dep, rs2_dep;
   logic          commit_ready;
   logic [RW-1:0] commit_rob_id;
   logic [4:0]    commit_reg_id;
   logic [31:0]   commit_val;
   logic [RW-1:0] search_rob_id_1, search_rob_id_2;
   logic          search_ready_1, search_ready_2;
   logic [31:0]   search_val_1, search_val_2;

   reg_file #(.ROB_WIDTH(RW), .REG_NUM(32)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .dec_ready(dec_ready), .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .rs1_val(rs1_val), .rs2_val(rs2_val),
      .rs1_dep_valid(rs1_dep_valid), .rs2_dep_valid(rs2_dep_valid),
      .rs1_dep(rs1_dep), .rs2_dep(rs2_dep),
      .commit_ready(commit_ready), .commit_rob_id(commit_rob_id),
      .commit_reg_id(commit_reg_id), .commit_val(commit_val),
      .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
      .search_ready_1(search_ready_1), .search_ready_2(search_ready_2),
      .search_val_1(search_val_1), .search_val_2(search_val_2)
   );

   always #5 clk_in = ~clk_in;

   // Reference state: value of each register and the ROB id it waits on (-1 = not pending).
   int unsigned m_val  [32];
   int          m_pend [32];
   int unsigned m_last [32];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_val[i]  = 0;
         m_pend[i] = -1;
         m_last[i] = 0;
      end
   endtask

   // Expected operand for one source using the rule priority over current reference state.
   task automatic expect_src(input int rs, input logic sr, input logic [31:0] sv,
                             output logic [31:0] v, output logic dv, output logic [RW-1:0] d);
      v = 0; dv = 0; d = 0;
      if (rs == 0) return;
      if (m_pend[rs] < 0) begin
         v = m_val[rs];
      end else if (commit_ready && int'(commit_reg_id) == rs && int'(commit_rob_id) == m_pend[rs]) begin
         v = commit_val;
      end else if (sr) begin
         v = sv;
      end else begin
         dv = 1;
         d  = RW'(m_pend[rs]);
      end
   endtask

   task automatic check_outputs();
      logic [31:0] v;
      logic dv;
      logic [RW-1:0] d;
      expect_src(int'(dec_rs1), search_ready_1, search_val_1, v, dv, d);
      check("rs1_val", rs1_val, v);
      check("rs1_dep_valid", 32'(rs1_dep_valid), 32'(dv));
      if (dv) check("rs1_dep", 32'(rs1_dep), 32'(d));
      check("search_rob_id_1", 32'(search_rob_id_1), (dec_rs1 == 0) ? 32'd0 : m_last[dec_rs1]);
      expect_src(int'(dec_rs2), search_ready_2, search_val_2, v, dv, d);
      check("rs2_val", rs2_val, v);
      check("rs2_dep_valid", 32'(rs2_dep_valid), 32'(dv));
      if (dv) check("rs2_dep", 32'(rs2_dep), 32'(d));
      check("search_rob_id_2", 32'(search_rob_id_2), (dec_rs2 == 0) ? 32'd0 : m_last[dec_rs2]);
   endtask

   // Check the live outputs, take one clock edge, advance the reference model.
   task automatic cycle();
      #1;
      check_outputs();
      @(posedge clk_in);
      if (rdy_in) begin
         if (commit_ready && commit_reg_id != 0) begin
            m_val[commit_reg_id] = commit_val;
            if (m_pend[commit_reg_id] == int'(commit_rob_id)) m_pend[commit_reg_id] = -1;
         end
         if (clear) begin
            for (int i = 0; i < 32; i++) m_pend[i] = -1;
         end else if (dec_ready && dec_rd != 0) begin
            m_pend[dec_rd] = int'(dec_rob_id);
            m_last[dec_rd] = dec_rob_id;
         end
      end
      @(negedge clk_in);
   endtask

   task automatic idle();
      rdy_in = 1; clear = 0;
      dec_ready = 0; dec_rd = 0; dec_rob_id = 0; dec_rs1 = 0; dec_rs2 = 0;
      commit_ready = 0; commit_rob_id = 0; commit_reg_id = 0; commit_val = 0;
      search_ready_1 = 0; search_ready_2 = 0; search_val_1 = 0; search_val_2 = 0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [RW-1:0] rob);
      idle(); dec_ready = 1; dec_rd = rd; dec_rob_id = rob; cycle();
   endtask

   task automatic commit(input logic [4:0] rd, input logic [RW-1:0] rob, input logic [31:0] val);
      idle(); commit_ready = 1; commit_reg_id = rd; commit_rob_id = rob; commit_val = val; cycle();
   endtask

   initial begin
      model_reset();
      idle();
      rst_in = 0;
      dec_rs1 = 5;
      #12;
      check("reset_rs1_val", rs1_val, 32'd0);
      check("reset_rs1_dep_valid", 32'(rs1_dep_valid), 32'd0);
      @(negedge clk_in);
      rst_in = 1;
      @(negedge clk_in);

      // untagged commit then read
      commit(5'd5, 4'd3, 32'h1234);
      idle(); dec_rs1 = 5; #1;
      check("commit_x5", rs1_val, 32'h1234);
      cycle();

      // rename then search forwarding
      issue(5'd7, 4'd2);
      idle(); dec_rs1 = 7; #1;
      check("pend_dv", 32'(rs1_dep_valid), 32'd1);
      check("pend_dep", 32'(rs1_dep), 32'd2);
      check("pend_srch", 32'(search_rob_id_1), 32'd2);
      search_ready_1 = 1; search_val_1 = 32'hAB; #1;
      check("search_val", rs1_val, 32'hAB);
      check("search_dv", 32'(rs1_dep_valid), 32'd0);
      cycle();

      // older commit keeps younger rename
      issue(5'd7, 4'd5);
      commit(5'd7, 4'd2, 32'd9);
      idle(); dec_rs1 = 7; #1;
      check("young_dep", 32'(rs1_dep), 32'd5);
      check("young_dv", 32'(rs1_dep_valid), 32'd1);
      cycle();

      // same-cycle commit forwarding
      idle(); commit_ready = 1; commit_reg_id = 7; commit_rob_id = 5; commit_val = 32'h55; dec_rs2 = 7; #1;
      check("fwd_val", rs2_val, 32'h55);
      check("fwd_dv", 32'(rs2_dep_valid), 32'd0);
      cycle();
      idle(); dec_rs2 = 7; #1;
      check("after_fwd_val", rs2_val, 32'h55);
      check("after_fwd_dv", 32'(rs2_dep_valid), 32'd0);
      cycle();

      // clear drops tags and the same-cycle issue
      commit(5'd1, 4'd0, 32'h11);
      issue(5'd1, 4'd1);
      issue(5'd2, 4'd2);
      issue(5'd3, 4'd3);
      idle(); clear = 1; dec_ready = 1; dec_rd = 4; dec_rob_id = 4; cycle();
      idle(); dec_rs1 = 1; dec_rs2 = 4; #1;
      check("clr_x1_val", rs1_val, 32'h11);
      check("clr_x1_dv", 32'(rs1_dep_valid), 32'd0);
      check("clr_x4_dv", 32'(rs2_dep_valid), 32'd0);
      cycle();

      // frozen when not ready
      idle(); rdy_in = 0; dec_ready = 1; dec_rd = 8; dec_rob_id = 6;
      commit_ready = 1; commit_reg_id = 8; commit_rob_id = 6; commit_val = 32'h77; cycle();
      idle(); dec_rs1 = 8; #1;
      check("frz_val", rs1_val, 32'd0);
      check("frz_dv", 32'(rs1_dep_valid), 32'd0);
      cycle();

      // x0 ignored
      idle(); dec_ready = 1; dec_rd = 0; dec_rob_id = 7;
      commit_ready = 1; commit_reg_id = 0; commit_rob_id = 7; commit_val = 32'hDEAD; cycle();
      idle(); dec_rs1 = 0; dec_rs2 = 0; search_ready_1 = 1; search_val_1 = 32'hFFFF; #1;
      check("x0_val", rs1_val, 32'd0);
      check("x0_dv", 32'(rs1_dep_valid), 32'd0);
      check("x0_srch", 32'(search_rob_id_1), 32'd0);
      cycle();

      // random traffic on a small register window for frequent collisions
      for (int n = 0; n < 3000; n++) begin
         rdy_in         = ($urandom_range(9) != 0);
         clear          = ($urandom_range(31) == 0);
         dec_ready      = $urandom_range(1);
         dec_rd         = 5'($urandom_range(7));
         dec_rob_id     = RW'($urandom);
         dec_rs1        = ($urandom_range(15) == 0) ? 5'($urandom) : 5'($urandom_range(7));
         dec_rs2        = 5'($urandom_range(7));
         commit_ready   = $urandom_range(1);
         commit_reg_id  = 5'($urandom_range(7));
         commit_rob_id  = $urandom_range(1) ? RW'(m_last[commit_reg_id]) : RW'($urandom);
         commit_val     = $urandom;
         search_ready_1 = $urandom_range(1);
         search_ready_2 = $urandom_range(1);
         search_val_1   = $urandom;
         search_val_2   = $urandom;
         cycle();
      end

      // asynchronous reset mid-cycle
      idle(); dec_rs1 = 5; dec_rs2 = 7;
      #2 rst_in = 0;
      #1;
      model_reset();
      check("areset_rs1_val", rs1_val, 32'd0);
      check("areset_rs2_val", rs2_val, 32'd0);
      check("areset_rs2_dv", 32'(rs2_dep_valid), 32'd0);
      @(negedge clk_in);
      rst_in = 1;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
